// File: rtl/csa_acc_resolve.sv
// Streaming carry-save accumulator: one 3:2 compression per operand, then a chunked CPA resolve.
// Latency: result valid NCHUNK cycles after the last operand; input stalls (in_ready=0) from last operand until the result handshakes.
module csa_acc_resolve #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNTW-1:0]  out_count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic              cy_q, cy_d;

    logic              in_hs;
    logic              last_chunk;
    logic [WIDTH-1:0]  maj;
    logic [CHUNK-1:0]  s_chunk;
    logic [CHUNK-1:0]  c_chunk;
    logic [CHUNK:0]    chunk_sum;

    assign in_hs      = in_valid & in_ready;
    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    assign maj        = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);

    // Resolve reads only the registered S/C, so one CHUNK-wide adder is reused every cycle
    assign s_chunk    = s_q[k_q*CHUNK +: CHUNK];
    assign c_chunk    = c_q[k_q*CHUNK +: CHUNK];
    assign chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (in_hs && in_last) state_d = ST_RES;
            ST_RES:  if (last_chunk)       state_d = ST_OUT;
            ST_OUT:  if (out_ready)        state_d = ST_ACC;
            default:                       state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_OUT);
    end

    always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        res_d = res_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        cy_d  = cy_q;
        case (state_q)
            ST_ACC: begin
                if (in_hs) begin
                    s_d   = s_q ^ c_q ^ in_data;
                    c_d   = maj << 1;
                    cnt_d = cnt_q + CNTW'(1);
                    if (in_last) begin
                        k_d  = '0;
                        cy_d = 1'b0;
                    end
                end
            end
            ST_RES: begin
                res_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                cy_d = chunk_sum[CHUNK];
                k_d  = k_q + KW'(1);
            end
            ST_OUT: begin
                if (out_ready) begin
                    s_d   = '0;
                    c_d   = '0;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            c_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
            cy_q  <= 1'b0;
        end else begin
            s_q   <= s_d;
            c_q   <= c_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
            cy_q  <= cy_d;
        end
    end

    assign out_sum   = res_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_acc_resolve.sv
// Directed + randomized checks of csa_acc_resolve against a plain-arithmetic packet-sum model.
module tb_csa_acc_resolve;

    localparam int W  = 64;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] pkt[$];
    logic [W-1:0] exp_sum;
    logic [W-1:0] hold_sum;
    logic [CW-1:0] hold_cnt;

    csa_acc_resolve #(.WIDTH(W), .CHUNK(16), .CNTW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_sum();
        logic [W-1:0] acc = '0;
        foreach (pkt[i]) acc = acc + pkt[i];
        return acc;
    endfunction

    task automatic send_op(input logic [W-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("send_timeout", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = $urandom_range(1);
        in_data  = {$urandom, $urandom};
    endtask

    task automatic send_pkt(input int gap_pct);
        for (int i = 0; i < pkt.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                int g = $urandom_range(3, 1);
                for (int j = 0; j < g; j++) step();
            end
            send_op(pkt[i], i == pkt.size() - 1);
        end
    endtask

    task automatic recv(input string tag, input logic [W-1:0] es, input int n_ops);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_count"}, {56'd0, out_count}, 64'(n_ops % 256));
        step();
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_pkt(input string tag, input int gap_pct);
        exp_sum = model_sum();
        send_pkt(gap_pct);
        recv(tag, exp_sum, pkt.size());
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_out_count", {56'd0, out_count}, 64'd0);
        #14 rst_n = 1'b1;
        step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 1,2,3 back-to-back with latency profile
        send_op(64'd1, 1'b0);
        send_op(64'd2, 1'b0);
        send_op(64'd3, 1'b1);
        check("lat_in_ready_drop", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lat_no_valid_%0d", i), {63'd0, out_valid}, 64'd0);
            step();
        end
        check("lat_valid_at_n", {63'd0, out_valid}, 64'd1);
        recv("p123", 64'd6, 3);

        pkt = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        run_pkt("wrap", 0);
        check("wrap_model", exp_sum, 64'd0);
        pkt = '{64'h0000_0000_0000_FFFF, 64'h1};
        run_pkt("chunk_carry", 0);
        check("chunk_carry_model", exp_sum, 64'h0000_0000_0001_0000);
        pkt = '{64'hDEAD_BEEF_0123_4567};
        run_pkt("single", 0);

        // Same 10 operands with and without gaps
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back({$urandom, $urandom});
        run_pkt("gapfree10", 0);
        run_pkt("gappy10", 60);

        // Backpressure
        out_ready = 1'b0;
        pkt = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h5555_AAAA_5555_AAAA};
        exp_sum = model_sum();
        send_pkt(0);
        for (int n = 0; n < 50 && !out_valid; n++) step();
        hold_sum = out_sum;
        hold_cnt = out_count;
        check("bp_sum", hold_sum, exp_sum);
        check("bp_count", {56'd0, hold_cnt}, 64'd3);
        for (int i = 0; i < 20; i++) begin
            in_valid = $urandom_range(1);
            in_last  = $urandom_range(1);
            in_data  = {$urandom, $urandom};
            step();
            check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
            check("bp_sum_hold", out_sum, hold_sum);
            check("bp_count_hold", {56'd0, out_count}, {56'd0, hold_cnt});
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        pkt = '{64'd4};
        run_pkt("bp_next_from_zero", 0);

        // Asynchronous reset while resolving chunk 2
        pkt = '{64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
        send_pkt(0);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_sum", out_sum, 64'd0);
        check("arst_out_count", {56'd0, out_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pkt = '{64'd5, 64'd7};
        run_pkt("post_reset", 0);
        check("post_reset_model", exp_sum, 64'd12);

        // Random packets, including a 300-operand one for counter wrap
        for (int p = 0; p < 6; p++) begin
            int len = (p == 0) ? 300 : $urandom_range(300, 1);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back({$urandom, $urandom});
            run_pkt($sformatf("rand_pkt%0d_len%0d", p, len), 20);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
